// File: rtl/perf_counters.sv
// rtl/perf_counters.sv - processor performance counters with registered readout; cache counters 4-7 built only with PERF_CACHE_CNT_EN
module perf_counters #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             halt,
  input  logic             reg_wrt,
  input  logic             mem_read,
  input  logic             mem_wrt,
  input  logic             icache_req,
  input  logic             icache_hit,
  input  logic             dcache_req,
  input  logic             dcache_hit,
  input  logic             rd_en,
  input  logic [2:0]       rd_sel,
  output logic [CNT_W-1:0] rd_data,
  output logic             rd_valid,
  output logic             halted
);

`ifdef PERF_CACHE_CNT_EN
  localparam int N_CNT = 8;
`else
  localparam int N_CNT = 4;
`endif

  typedef enum logic {
    S_RUN    = 1'b0,
    S_HALTED = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_count_en;
  logic [N_CNT-1:0] w_evt;
  logic [CNT_W-1:0] r_cnt [N_CNT];
  logic [CNT_W-1:0] w_sel_val;
  logic [CNT_W-1:0] r_rd_data;
  logic             r_rd_valid;

`ifndef PERF_CACHE_CNT_EN
  // Cache strobes have no counters in this build; fold them into a sink.
  logic w_unused;
  assign w_unused = &{1'b0, icache_req, icache_hit, dcache_req, dcache_hit};
`endif

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_RUN;
    else     r_state <= w_state_nxt;
  end

  // Next state and count enable; clr overrides halt and forces RUN
  always_comb begin
    w_state_nxt = r_state;
    w_count_en  = 1'b0;
    case (r_state)
      S_RUN: begin
        w_count_en = 1'b1;
        if (halt) w_state_nxt = S_HALTED;
      end
      S_HALTED: w_state_nxt = S_HALTED;
      default:  w_state_nxt = S_RUN;
    endcase
    if (clr) begin
      w_state_nxt = S_RUN;
      w_count_en  = 1'b0;
    end
  end

  // Per-counter event strobes; inst counts at most once per cycle
  always_comb begin
    w_evt    = '0;
    w_evt[0] = 1'b1;
    w_evt[1] = halt | reg_wrt | mem_wrt;
    w_evt[2] = mem_read;
    w_evt[3] = mem_wrt;
`ifdef PERF_CACHE_CNT_EN
    w_evt[4] = icache_req;
    w_evt[5] = icache_hit;
    w_evt[6] = dcache_req;
    w_evt[7] = dcache_hit;
`endif
  end

  // Saturating counters, cleared by clr, frozen while halted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CNT; i++) r_cnt[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < N_CNT; i++) r_cnt[i] <= '0;
    end else if (w_count_en) begin
      for (int i = 0; i < N_CNT; i++) begin
        if (w_evt[i] && (r_cnt[i] != '1)) r_cnt[i] <= r_cnt[i] + CNT_W'(1);
      end
    end
  end

  // Readout mux; unbuilt counter indices read as zero
  always_comb begin
    w_sel_val = '0;
    for (int i = 0; i < N_CNT; i++) begin
      if (rd_sel == 3'(i)) w_sel_val = r_cnt[i];
    end
  end

  // Registered readout of the pre-update counter value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= rd_en;
      if (rd_en) r_rd_data <= w_sel_val;
    end
  end

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign halted   = (r_state == S_HALTED);

endmodule

// File: tb/tb_perf_counters.sv
// tb/tb_perf_counters.sv - directed self-checking bench for perf_counters
module tb_perf_counters;

  logic        clk = 1'b0;
  logic        rst, clr, halt, reg_wrt, mem_read, mem_wrt;
  logic        icache_req, icache_hit, dcache_req, dcache_hit;
  logic        rd_en;
  logic [2:0]  rd_sel;
  logic [31:0] rd_data;
  logic        rd_valid, halted;
  logic [3:0]  rd_data4;
  logic        rd_valid4, halted4;

  int n_cmp  = 0;
  int n_fail = 0;

`ifdef PERF_CACHE_CNT_EN
  localparam logic CACHE_ON = 1'b1;
`else
  localparam logic CACHE_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  perf_counters #(.CNT_W(32)) u_dut (
    .clk(clk), .rst(rst), .clr(clr), .halt(halt), .reg_wrt(reg_wrt),
    .mem_read(mem_read), .mem_wrt(mem_wrt),
    .icache_req(icache_req), .icache_hit(icache_hit),
    .dcache_req(dcache_req), .dcache_hit(dcache_hit),
    .rd_en(rd_en), .rd_sel(rd_sel),
    .rd_data(rd_data), .rd_valid(rd_valid), .halted(halted)
  );

  perf_counters #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .clr(clr), .halt(halt), .reg_wrt(reg_wrt),
    .mem_read(mem_read), .mem_wrt(mem_wrt),
    .icache_req(icache_req), .icache_hit(icache_hit),
    .dcache_req(dcache_req), .dcache_hit(dcache_hit),
    .rd_en(rd_en), .rd_sel(rd_sel),
    .rd_data(rd_data4), .rd_valid(rd_valid4), .halted(halted4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle readout; checks the wide DUT and optionally the 4-bit DUT.
  task automatic rd(input string tag, input logic [2:0] sel, input logic [31:0] exp32,
                    input logic chk4, input logic [31:0] exp4);
    rd_en  = 1'b1;
    rd_sel = sel;
    @(negedge clk);
    rd_en = 1'b0;
    check({tag, " valid"}, {31'd0, rd_valid}, 32'd1);
    check({tag, " data"}, rd_data, exp32);
    if (chk4) check({tag, " data4"}, {28'd0, rd_data4}, exp4);
  endtask

  task automatic pulse_clr;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; halt = 1'b0; reg_wrt = 1'b0; mem_read = 1'b0; mem_wrt = 1'b0;
    icache_req = 1'b0; icache_hit = 1'b0; dcache_req = 1'b0; dcache_hit = 1'b0;
    rd_en = 1'b0; rd_sel = 3'd0;
    step(2);
    check("reset rd_valid", {31'd0, rd_valid}, 32'd0);
    check("reset rd_data", rd_data, 32'd0);
    check("reset halted", {31'd0, halted}, 32'd0);

    // rst then 10 idle cycles, read cycle counter
    rst = 1'b0;
    step(10);
    rd("cycle10", 3'd0, 32'd10, 1'b0, 32'd0);
    step(1);
    check("rd_valid one cycle", {31'd0, rd_valid}, 32'd0);
    check("rd_data hold", rd_data, 32'd10);

    // inst/store/load mix
    pulse_clr();
    reg_wrt = 1'b1; mem_wrt = 1'b1;
    step(1);
    reg_wrt = 1'b0; mem_wrt = 1'b0; mem_read = 1'b1;
    step(3);
    mem_read = 1'b0;
    rd("inst", 3'd1, 32'd1, 1'b0, 32'd0);
    rd("store", 3'd3, 32'd1, 1'b0, 32'd0);
    rd("load", 3'd2, 32'd3, 1'b0, 32'd0);
    rd("cycle7", 3'd0, 32'd7, 1'b0, 32'd0);

    // halt with reg_wrt after 20 running cycles, then events ignored
    pulse_clr();
    step(20);
    halt = 1'b1; reg_wrt = 1'b1;
    step(1);
    halt = 1'b0;
    check("halted set", {31'd0, halted}, 32'd1);
    mem_read = 1'b1;
    step(5);
    reg_wrt = 1'b0; mem_read = 1'b0;
    rd("halt inst", 3'd1, 32'd1, 1'b0, 32'd0);
    rd("halt cycle", 3'd0, 32'd21, 1'b0, 32'd0);
    rd("halt load", 3'd2, 32'd0, 1'b0, 32'd0);
    check("halted after reads", {31'd0, halted}, 32'd1);

    // clr and halt together leave RUN with zeroed counters
    clr = 1'b1; halt = 1'b1;
    step(1);
    clr = 1'b0; halt = 1'b0;
    check("clr beats halt", {31'd0, halted}, 32'd0);
    rd("clr cycle", 3'd0, 32'd0, 1'b0, 32'd0);
    rd("clr inst", 3'd1, 32'd0, 1'b0, 32'd0);
    rd("run again", 3'd0, 32'd2, 1'b0, 32'd0);

    // readout in the clr cycle returns the pre-clear value
    clr = 1'b1;
    rd("rd with clr", 3'd0, 32'd3, 1'b0, 32'd0);
    clr = 1'b0;
    rd("after clr", 3'd0, 32'd0, 1'b1, 32'd0);

    // saturation at CNT_W=4
    pulse_clr();
    mem_read = 1'b1; icache_req = 1'b1;
    step(20);
    mem_read = 1'b0; icache_req = 1'b0;
    rd("sat load", 3'd2, 32'd20, 1'b1, 32'd15);
    rd("sat icache", 3'd4, CACHE_ON ? 32'd20 : 32'd0, 1'b1, CACHE_ON ? 32'd15 : 32'd0);
    rd("sat cycle4", 3'd0, 32'd22, 1'b1, 32'd15);
    pulse_clr();
    rd("sat clr load", 3'd2, 32'd0, 1'b1, 32'd0);
    rd("sat clr icache", 3'd4, 32'd0, 1'b1, 32'd0);

    // dcache_hit strobes
    dcache_hit = 1'b1;
    step(5);
    dcache_hit = 1'b0;
    rd("dcache_hit", 3'd7, CACHE_ON ? 32'd5 : 32'd0, 1'b1, CACHE_ON ? 32'd5 : 32'd0);

    // asynchronous reset while halted with a readout pending
    pulse_clr();
    step(2);
    rd("pre rst", 3'd0, 32'd2, 1'b0, 32'd0);
    halt = 1'b1;
    step(1);
    halt = 1'b0;
    check("halted pre rst", {31'd0, halted}, 32'd1);
    rd_en = 1'b1; rd_sel = 3'd0;
    #2 rst = 1'b1;
    #1;
    check("async rd_data", rd_data, 32'd0);
    check("async rd_valid", {31'd0, rd_valid}, 32'd0);
    check("async halted", {31'd0, halted}, 32'd0);
    @(negedge clk);
    rd_en = 1'b0;
    check("pending discarded", {31'd0, rd_valid}, 32'd0);
    rst = 1'b0;
    step(3);
    rd("post rst cycle", 3'd0, 32'd3, 1'b0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/perf_counters.md
PERF_COUNTERS -- requirements
Module: perf_counters

Interface
REQ-001 The block SHALL have parameter CNT_W, default 32, giving the width of every counter and of rd_data.
REQ-002 The block SHALL have port clk, input, 1 bit, the single processor clock.
REQ-003 The block SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-004 The block SHALL have port clr, input, 1 bit, synchronous clear of all counters and of the halted state.
REQ-005 The block SHALL have port halt, input, 1 bit, halt instruction committing this cycle.
REQ-006 The block SHALL have port reg_wrt, input, 1 bit, register file write committing this cycle.
REQ-007 The block SHALL have port mem_read, input, 1 bit, data memory read this cycle.
REQ-008 The block SHALL have port mem_wrt, input, 1 bit, data memory write this cycle.
REQ-009 The block SHALL have ports icache_req, icache_hit, dcache_req and dcache_hit, each an input of 1 bit, each a per-cycle cache event strobe.
REQ-010 The block SHALL have port rd_en, input, 1 bit, counter readout request.
REQ-011 The block SHALL have port rd_sel, input, 3 bits, counter index.
REQ-012 The block SHALL have port rd_data, output, CNT_W bits, registered counter value.
REQ-013 The block SHALL have port rd_valid, output, 1 bit, qualifies rd_data.
REQ-014 The block SHALL have port halted, output, 1 bit, high while counting is frozen after halt.

Function
REQ-015 The counter indices SHALL be: 0 cycle, 1 inst, 2 load, 3 store, 4 icache_req, 5 icache_hit, 6 dcache_req, 7 dcache_hit.
REQ-016 The block SHALL implement a two-state FSM: RUN and HALTED.
REQ-017 In RUN, the cycle counter SHALL increment every clk edge.
REQ-018 In RUN, inst SHALL increment when (halt | reg_wrt | mem_wrt), by at most 1 per cycle.
REQ-019 In RUN, load SHALL increment on mem_read, store on mem_wrt, and each cache counter on its strobe.
REQ-020 When halt=1 in RUN, that cycle's events SHALL be counted and the FSM SHALL enter HALTED at the same edge.
REQ-021 In HALTED, all counters SHALL hold, all event inputs SHALL be ignored, and halted SHALL be 1.
REQ-022 The only exits from HALTED SHALL be clr and rst, each returning the FSM to RUN.
REQ-023 When clr=1, every counter SHALL load 0 and the FSM SHALL enter RUN at that edge, taking priority over any simultaneous event or halt.
REQ-024 Each counter SHALL saturate at 2^CNT_W-1 with no wrap, holding that value until clr or rst.
REQ-025 Readout SHALL have 1-cycle latency: rd_en sampled at edge N gives rd_valid=1 after edge N, for one cycle only.
REQ-026 The rd_data presented after edge N SHALL be the selected counter's value before edge N's update.
REQ-027 When rd_en=0, rd_valid SHALL be 0 and rd_data SHALL hold its previous value.
REQ-028 Readout SHALL be legal in both states and SHALL NOT disturb counting.
REQ-029 Readout issued in the same cycle as clr SHALL return the pre-clear value.

Reset
REQ-030 Assertion of rst SHALL immediately, without waiting for a clk edge, force every counter to 0, rd_data to 0, rd_valid to 0, halted to 0, and the FSM to RUN.
REQ-031 Assertion of rst mid-operation, including in HALTED or with rd_en pending, SHALL discard the pending readout.
REQ-032 No event SHALL be counted on the first edge at which rst is deasserted, because rst is then still high.

Configuration
REQ-033 With macro PERF_CACHE_CNT_EN defined, the block SHALL implement counters 4-7 as specified above.
REQ-034 With PERF_CACHE_CNT_EN undefined, counters 4-7 SHALL not be built, the four cache inputs SHALL be ignored, and a readout of rd_sel 4-7 SHALL return rd_valid=1 with rd_data=0.

Verification
REQ-035 Scenario: rst, then 10 idle cycles, then rd_en with rd_sel=0 -> rd_data=10 and rd_valid=1 for exactly one cycle.
REQ-036 Scenario: reg_wrt and mem_wrt both high for 1 cycle, then mem_read for 3 cycles -> inst=1, store=1, load=3.
REQ-037 Scenario: halt pulsed with reg_wrt=1 at cycle 20, then reg_wrt held high for 5 more cycles -> halted=1, inst frozen with the halt cycle counted once, cycle=21.
REQ-038 Scenario: CNT_W=4 with icache_req high for 20 cycles -> counter 4 reads 15; clr then sets it to 0.
REQ-039 Scenario: clr and halt asserted in the same cycle -> halted=0 and all counters 0.
REQ-040 Scenario: build without PERF_CACHE_CNT_EN, dcache_hit high for 5 cycles, read rd_sel=7 -> rd_data=0.
